rally_controller: RTL
=====================

Name: rally_controller

Overview:
- Game-flow sequencer for the volley game, clocked in the 65 MHz pixel domain.
- Sequences each point through the same cycle: wait for serve, release the ball, count touches per side, award the point, hold for a delay, then re-serve.
- Drives the ball datapath (hold/release) and keeps both scores.
- Takes per-frame ticks from the VGA timing and debounced-level clicks from the mouse path. Takes contact and floor pulses from the ball/collision logic.

Parameters:
- WIN_SCORE, 15, score that ends the game
- MAX_TOUCHES, 3, legal consecutive touches per side before a fault
- POINT_DELAY_FRAMES, 120, frames held in POINT before the next serve
- SCORE_W, 5, score counter width; must satisfy 2**SCORE_W > WIN_SCORE

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- p1_click  in  1  player-1 mouse button, level
- p2_click  in  1  player-2 mouse button, level
- p1_touch  in  1  one-cycle pulse: ball contacted player 1
- p2_touch  in  1  one-cycle pulse: ball contacted player 2
- ball_floor  in  1  one-cycle pulse: ball hit the floor
- ball_side  in  1  side of the ball at ball_floor (0 = p1/left, 1 = p2/right)
- ball_hold  out  1  level: ball datapath parks the ball above serve_side
- ball_release  out  1  one-cycle pulse: start ball motion
- serve_side  out  1  0 = p1 serves, 1 = p2 serves
- score_p1  out  SCORE_W  player-1 score
- score_p2  out  SCORE_W  player-2 score
- touch_cnt  out  2  consecutive touches by last_side
- game_over  out  1  level, high in state OVER
- winner  out  1  valid while game_over (0 = p1, 1 = p2)

Behaviour:
- All outputs are registered. Inputs are sampled on pclk rising edge. A state change takes effect on the cycle after the qualifying input.
- Reset values:
  - state = IDLE
  - scores = 0, touch_cnt = 0
  - serve_side = 0, ball_hold = 1, ball_release = 0
  - game_over = 0, winner = 0
  - delay counter = 0
  - click edge registers = 0
- Reset mid-rally or mid-delay abandons the point. Nothing is awarded.
- Clicks: each click is registered and rising-edge detected internally. A held button produces exactly one event.
- States:
  - IDLE: ball_hold = 1. A rise on either click enters SERVE.
  - SERVE: ball_hold = 1. Only the serving player's click rise is accepted. On that rise: ball_release pulses for one cycle, ball_hold drops to 0, touch_cnt = 0, and the state becomes RALLY. The other player's click is ignored.
  - RALLY: evaluated in priority order:
    1. ball_floor: the point goes to !ball_side. Floor wins over a touch in the same cycle.
    2. p1_touch and p2_touch together: both ignored, no count change.
    3. A single touch from side s:
       - s == last_side: touch_cnt + 1.
       - otherwise: last_side = s, touch_cnt = 1.
       - If the new count would exceed MAX_TOUCHES: the point goes to !s and touch_cnt is left unchanged.
  - Award point: increment the winner's score and set serve_side to the scorer. Set ball_hold = 1, clear the delay counter and enter POINT.
  - POINT: count frame_tick pulses.
    - If the scorer's score == WIN_SCORE: enter OVER on entry to POINT's first cycle (no delay). Set winner to the scorer.
    - Otherwise, on the tick that brings the count to POINT_DELAY_FRAMES, enter SERVE.
    - Clicks and touches are ignored.
  - OVER: game_over = 1, ball_hold = 1. A click rise from either player clears the scores, touch_cnt, game_over and serve_side, then enters IDLE.
- Scores never exceed WIN_SCORE. Saturating logic is required even though OVER prevents further increments.
- touch_cnt is 2 bits wide, so MAX_TOUCHES is limited to 3 or fewer. A synthesis-time check enforces this.
- Touch and floor pulses outside RALLY are ignored.
- A frame_tick coinciding with the point award is not counted.

Decomposition:
- Shared package game_pkg:
  - state encoding: IDLE, SERVE, RALLY, POINT, OVER (3-bit)
  - side constants: SIDE_P1 = 0, SIDE_P2 = 1
- Sub-module: edge_rise, a registered rising-edge detector instantiated once per click.
- The delay counter and scoring stay inline.

Test Plan:
- Reset, then p1_click rise → SERVE. p2_click → no effect. p1_click → ball_release high for exactly 1 cycle, ball_hold = 0, state RALLY.
- In RALLY, ball_floor with ball_side = 0 → score_p2 = 1 and serve_side = 1 next cycle. After 120 frame_ticks → SERVE, and only p2_click releases.
- In RALLY: p1_touch ×3 → touch_cnt = 3. A 4th p1_touch → score_p2 increments. The sequence p1, p1, p2 gives touch_cnt = 1, with no fault.
- p1_touch, p2_touch and ball_floor (ball_side = 1) in the same cycle → only score_p1 increments and touch_cnt is unchanged. p1_touch and p2_touch alone in the same cycle → no change.
- score_p1 = 14 and p1 wins a point → score_p1 = 15, game_over = 1, winner = 0 with no delay. A held click gives one exit to IDLE with scores 0.
- Assert rst during POINT with delay count 60 → the next cycle shows the full reset values and no score change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the volley game flow:
// sequencer states and side identifiers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    RALLY,
    POINT,
    OVER
  } state_t;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

endpackage

// File: rtl/rally_controller_if.sv
// Game-side bundle between the rally controller and the
// timing, mouse and ball/collision logic.
interface rally_controller_if #(
  parameter int SCORE_W = 5
);
  logic               frame_tick;
  logic               p1_click;
  logic               p2_click;
  logic               p1_touch;
  logic               p2_touch;
  logic               ball_floor;
  logic               ball_side;
  logic               ball_hold;
  logic               ball_release;
  logic               serve_side;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         touch_cnt;
  logic               game_over;
  logic               winner;

  modport master (
    output frame_tick, p1_click, p2_click,
    output p1_touch, p2_touch,
    output ball_floor, ball_side,
    input  ball_hold, ball_release, serve_side,
    input  score_p1, score_p2, touch_cnt,
    input  game_over, winner
  );

  modport slave (
    input  frame_tick, p1_click, p2_click,
    input  p1_touch, p2_touch,
    input  ball_floor, ball_side,
    output ball_hold, ball_release, serve_side,
    output score_p1, score_p2, touch_cnt,
    output game_over, winner
  );
endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for a level input; the previous
// sample is registered so a held level yields one event.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/rally_controller.sv
// Volley game-flow sequencer: serve, rally touch counting,
// point award, inter-point delay and game-over handling.
module rally_controller
  import game_pkg::*;
#(
  parameter int WIN_SCORE          = 15,
  parameter int MAX_TOUCHES        = 3,
  parameter int POINT_DELAY_FRAMES = 120,
  parameter int SCORE_W            = 5
) (
  input  logic         pclk,
  input  logic         rst,
  rally_controller_if.slave bus
);
  localparam int DLY_W = $clog2(POINT_DELAY_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);
  localparam logic [1:0]         MAX_T = 2'(MAX_TOUCHES);
  localparam logic [DLY_W-1:0]   DLY_LAST =
    DLY_W'(POINT_DELAY_FRAMES - 1);

  if (MAX_TOUCHES > 3 || MAX_TOUCHES < 1) begin : g_bad_touch
    $error("MAX_TOUCHES must be 1..3");
  end
  if ((2 ** SCORE_W) <= WIN_SCORE) begin : g_bad_score
    $error("SCORE_W too narrow for WIN_SCORE");
  end

  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_s1, w_s1_nxt;
  logic [SCORE_W-1:0] r_s2, w_s2_nxt;
  logic [1:0]         r_touch, w_touch_nxt;
  logic               r_last, w_last_nxt;
  logic               r_serve, w_serve_nxt;
  logic               r_hold, w_hold_nxt;
  logic               r_rel, w_rel_nxt;
  logic               r_over, w_over_nxt;
  logic               r_win, w_win_nxt;
  logic [DLY_W-1:0]   r_dly, w_dly_nxt;

  logic w_r1, w_r2;
  logic w_award, w_pt_side, w_ts;

  edge_rise u_p1_rise (
    .clk    (pclk),
    .rst    (rst),
    .i_d    (bus.p1_click),
    .o_rise (w_r1)
  );

  edge_rise u_p2_rise (
    .clk    (pclk),
    .rst    (rst),
    .i_d    (bus.p2_click),
    .o_rise (w_r2)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_touch <= '0;
      r_last  <= SIDE_P1;
      r_serve <= SIDE_P1;
      r_hold  <= 1'b1;
      r_rel   <= 1'b0;
      r_over  <= 1'b0;
      r_win   <= 1'b0;
      r_dly   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s1    <= w_s1_nxt;
      r_s2    <= w_s2_nxt;
      r_touch <= w_touch_nxt;
      r_last  <= w_last_nxt;
      r_serve <= w_serve_nxt;
      r_hold  <= w_hold_nxt;
      r_rel   <= w_rel_nxt;
      r_over  <= w_over_nxt;
      r_win   <= w_win_nxt;
      r_dly   <= w_dly_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_touch_nxt = r_touch;
    w_last_nxt  = r_last;
    w_serve_nxt = r_serve;
    w_hold_nxt  = r_hold;
    w_rel_nxt   = 1'b0;
    w_over_nxt  = r_over;
    w_win_nxt   = r_win;
    w_dly_nxt   = r_dly;
    w_award     = 1'b0;
    w_pt_side   = SIDE_P1;
    w_ts        = bus.p2_touch;

    unique case (r_state)
      IDLE: begin
        if (w_r1 | w_r2) w_state_nxt = SERVE;
      end
      SERVE: begin
        if ((r_serve == SIDE_P2) ? w_r2 : w_r1) begin
          w_rel_nxt   = 1'b1;
          w_hold_nxt  = 1'b0;
          w_touch_nxt = '0;
          w_last_nxt  = r_serve;
          w_state_nxt = RALLY;
        end
      end
      RALLY: begin
        if (bus.ball_floor) begin
          w_award   = 1'b1;
          w_pt_side = ~bus.ball_side;
        end else if (bus.p1_touch ^ bus.p2_touch) begin
          if (w_ts != r_last) begin
            w_last_nxt  = w_ts;
            w_touch_nxt = 2'd1;
          end else if (r_touch >= MAX_T) begin
            // Over-touch fault: count is frozen at the limit.
            w_award   = 1'b1;
            w_pt_side = ~w_ts;
          end else begin
            w_touch_nxt = r_touch + 2'd1;
          end
        end
      end
      POINT: begin
        if (((r_serve == SIDE_P2) ? r_s2 : r_s1) == WIN_S) begin
          w_state_nxt = OVER;
          w_over_nxt  = 1'b1;
          w_win_nxt   = r_serve;
        end else if (bus.frame_tick) begin
          w_dly_nxt = r_dly + 1'b1;
          if (r_dly == DLY_LAST) w_state_nxt = SERVE;
        end
      end
      OVER: begin
        if (w_r1 | w_r2) begin
          w_s1_nxt    = '0;
          w_s2_nxt    = '0;
          w_touch_nxt = '0;
          w_over_nxt  = 1'b0;
          w_serve_nxt = SIDE_P1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_award) begin
      if (w_pt_side == SIDE_P2) begin
        if (r_s2 != WIN_S) w_s2_nxt = r_s2 + 1'b1;
      end else begin
        if (r_s1 != WIN_S) w_s1_nxt = r_s1 + 1'b1;
      end
      w_serve_nxt = w_pt_side;
      w_hold_nxt  = 1'b1;
      w_dly_nxt   = '0;
      w_state_nxt = POINT;
    end
  end

  assign bus.ball_hold    = r_hold;
  assign bus.ball_release = r_rel;
  assign bus.serve_side   = r_serve;
  assign bus.score_p1     = r_s1;
  assign bus.score_p2     = r_s2;
  assign bus.touch_cnt    = r_touch;
  assign bus.game_over    = r_over;
  assign bus.winner       = r_win;
endmodule
